exec_stage_mc: RTL
==================

EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter W, default 16: datapath width in bits, legal 8..64, power of two.
REQ-002 Parameter REG_W, default 4: register-specifier width.
REQ-003 Ports (name dir width meaning):
 clk in 1 sole clock, all state updates on its rising edge;
 reset in 1 synchronous, active-high;
 in_valid in 1 decode presents an op; in_ready out 1 stage can accept;
 flush in 1 kill in-flight op;
 i_reg_write, i_alu_src, i_mem_write, i_mem_read, i_reg_store in 1 each: decode controls;
 i_alu_op in 3 ALU opcode;
 i_pcp2, i_arg1, i_arg2, i_arg3, i_imm in W each: PC+2, operands, immediate;
 i_rs1, i_rs2, i_rd in REG_W each: register specifiers;
 fwd_mem, fwd_wb in W: forwarded MEM ALU result, WB load data;
 fwd1_sel, fwd2_sel in 2; fwd3_sel in 1: forwarding selects;
 out_valid out 1 EX/MEM holds a fresh result;
 out_reg_write, out_reg_store, out_mem_write, out_mem_read out 1 each;
 out_pcp2, out_alu_result, out_arg3 out W; out_rs1, out_rs2, out_rd out REG_W.

Function
REQ-004 Internal ID/EX register with valid bit captures all i_* on edge where in_valid && in_ready (acceptance edge E0).
REQ-005 Operand A = fwd1_sel 00:fwd_mem, 01:fwd_wb, 10:ID/EX arg1, 11:0; operand B' same coding on fwd2_sel with arg2.
REQ-006 ALU input B = ID/EX imm when alu_src=1, else B'.
REQ-007 Store data = fwd3_sel 0:fwd_wb, 1:ID/EX arg3.
REQ-008 Forwarding selects and fwd_* sampled only in first execute cycle (cycle after E0); ignored afterwards.
REQ-009 Opcodes, results mod 2^W: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 A<<B[log2(W)-1:0], 110 signed A<B ? 1 : 0, 111 MUL low W bits of A*B.
REQ-010 States: IDLE (ID/EX empty), EX (ID/EX valid), MUL (iterating).
REQ-011 Single-cycle op: EX/MEM registered at E0+1 with out_valid=1; latency 1 edge after acceptance.
REQ-012 MUL: at E0+1 A, B, store data latched, W-step counter loaded, state MUL; one shift-add step per edge; EX/MEM loaded at E0+1+W with out_valid=1.
REQ-013 in_ready = !reset && !flush && state!=MUL && !(ID/EX valid && op==111).
REQ-014 While ready, new op accepted in same edge previous single-cycle op retires (back-to-back, 1 op/cycle).
REQ-015 out_valid high exactly one cycle per op; when low, out_reg_write, out_mem_write, out_mem_read, out_reg_store SHALL be 0; data outputs hold last value.
REQ-016 flush: ID/EX valid cleared, MUL aborted, state IDLE, out_valid 0 on next edge; op offered same cycle not accepted.
REQ-017 Control/specifier/pcp2 fields pass to EX/MEM unchanged alongside result.
REQ-018 Unused ID/EX contents SHALL not cause any out_valid pulse.

Reset
REQ-019 reset high at edge: state IDLE, ID/EX valid 0, counter 0, all outputs 0; in_ready 0 during reset cycle, 1 first cycle after.
REQ-020 reset mid-MUL aborts with no result; reset overrides flush and in_valid.

Verification (W=16)
REQ-021 ADD: arg1=0x0003, arg2=0x0004, sel=10/10, alu_src=0, rd=5 -> next edge out_valid=1, result 0x0007, out_rd=5.
REQ-022 Forward: fwd1_sel=00 fwd_mem=0x1000, imm=0x0010, alu_src=1, op SUB -> result 0x0FF0; fwd3_sel=0 fwd_wb=0xBEEF -> out_arg3=0xBEEF.
REQ-023 MUL: A=0x0123, B=0x0011 -> in_ready low from cycle after E0 for 17 cycles, out_valid at E0+17, result 0x1353; single pulse.
REQ-024 Back-to-back: ADD then XOR (0xFF00^0x0FF0) on consecutive edges -> out_valid two consecutive cycles, results in order, second 0xF0F0.
REQ-025 Flush at E0+5 of MUL -> no out_valid, in_ready 1 next cycle, following ADD completes normally.
REQ-026 SLT 0x8000 vs 0x0001 -> 0x0001; SLL 0x0001 by 0x0013 -> 0x0008; reset asserted mid-MUL -> all outputs 0, no result.

Source files
------------

// File: rtl/exec_stage_mc.sv
// Execute stage: ID/EX register, operand forwarding, single-cycle ALU and a
// W-step shift-add multiplier, all feeding a registered EX/MEM output.
module exec_stage_mc #(
    parameter int W     = 16,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             i_reg_write,
    input  logic             i_alu_src,
    input  logic             i_mem_write,
    input  logic             i_mem_read,
    input  logic             i_reg_store,
    input  logic [2:0]       i_alu_op,
    input  logic [W-1:0]     i_pcp2,
    input  logic [W-1:0]     i_arg1,
    input  logic [W-1:0]     i_arg2,
    input  logic [W-1:0]     i_arg3,
    input  logic [W-1:0]     i_imm,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [REG_W-1:0] i_rd,
    input  logic [W-1:0]     fwd_mem,
    input  logic [W-1:0]     fwd_wb,
    input  logic [1:0]       fwd1_sel,
    input  logic [1:0]       fwd2_sel,
    input  logic             fwd3_sel,
    output logic             out_valid,
    output logic             out_reg_write,
    output logic             out_reg_store,
    output logic             out_mem_write,
    output logic             out_mem_read,
    output logic [W-1:0]     out_pcp2,
    output logic [W-1:0]     out_alu_result,
    output logic [W-1:0]     out_arg3,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd
);
    // state | meaning
    // IDLE  | ID/EX empty
    // EX    | ID/EX valid, op in its first execute cycle
    // MUL   | multiplier iterating; ID/EX still holds the MUL's fields
    typedef enum logic [1:0] {IDLE, EX, MUL} stateT;

    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(W + 1);
    localparam logic [2:0] OP_MUL = 3'b111;

    stateT state, stateNext;
    logic accept, retire, mulStart, mulDone, idexMul, loadOut;

    logic             idRegWrite, idAluSrc, idMemWrite, idMemRead, idRegStore;
    logic [2:0]       idAluOp;
    logic [W-1:0]     idPcp2, idArg1, idArg2, idArg3, idImm;
    logic [REG_W-1:0] idRs1, idRs2, idRd;

    logic [W-1:0]  mulAcc, mulCand, mulPlier, mulStore, mulFinal;
    logic [CW-1:0] mulCnt;
    logic [W-1:0]  opA, opB, aluB, storeData, aluResult;

    assign idexMul  = (state == EX) && (idAluOp == OP_MUL);
    assign in_ready = !reset && !flush && (state != MUL) && !idexMul;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opA = '0;
        case (fwd1_sel)
            2'b00:   opA = fwd_mem;
            2'b01:   opA = fwd_wb;
            2'b10:   opA = idArg1;
            default: opA = '0;
        endcase
        opB = '0;
        case (fwd2_sel)
            2'b00:   opB = fwd_mem;
            2'b01:   opB = fwd_wb;
            2'b10:   opB = idArg2;
            default: opB = '0;
        endcase
    end

    assign aluB      = idAluSrc ? idImm : opB;
    assign storeData = fwd3_sel ? idArg3 : fwd_wb;

    // MUL never retires through this path; it goes through the iterative unit
    always_comb begin
        aluResult = '0;
        case (idAluOp)
            3'b000:  aluResult = opA + aluB;
            3'b001:  aluResult = opA - aluB;
            3'b010:  aluResult = opA & aluB;
            3'b011:  aluResult = opA | aluB;
            3'b100:  aluResult = opA ^ aluB;
            3'b101:  aluResult = opA << aluB[SHW-1:0];
            3'b110:  aluResult = {{(W-1){1'b0}}, ($signed(opA) < $signed(aluB))};
            default: aluResult = '0;
        endcase
    end

    // Last shift-add step is folded into the EX/MEM load
    assign mulFinal = mulAcc + (mulPlier[0] ? mulCand : '0);

    always_comb begin
        stateNext = state;
        retire    = 1'b0;
        mulStart  = 1'b0;
        mulDone   = 1'b0;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) stateNext = EX;
                EX: begin
                    if (idAluOp == OP_MUL) begin
                        mulStart  = 1'b1;
                        stateNext = MUL;
                    end else begin
                        retire    = 1'b1;
                        stateNext = accept ? EX : IDLE;
                    end
                end
                MUL: begin
                    if (mulCnt == CW'(1)) begin
                        mulDone   = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    assign loadOut = retire || mulDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            {idRegWrite, idAluSrc, idMemWrite, idMemRead, idRegStore} <= '0;
            idAluOp <= '0;
            {idPcp2, idArg1, idArg2, idArg3, idImm} <= '0;
            {idRs1, idRs2, idRd} <= '0;
            {mulAcc, mulCand, mulPlier, mulStore} <= '0;
            mulCnt <= '0;
            {out_valid, out_reg_write, out_reg_store, out_mem_write, out_mem_read} <= '0;
            {out_pcp2, out_alu_result, out_arg3} <= '0;
            {out_rs1, out_rs2, out_rd} <= '0;
        end else begin
            if (accept) begin
                idRegWrite <= i_reg_write;
                idAluSrc   <= i_alu_src;
                idMemWrite <= i_mem_write;
                idMemRead  <= i_mem_read;
                idRegStore <= i_reg_store;
                idAluOp    <= i_alu_op;
                idPcp2     <= i_pcp2;
                idArg1     <= i_arg1;
                idArg2     <= i_arg2;
                idArg3     <= i_arg3;
                idImm      <= i_imm;
                idRs1      <= i_rs1;
                idRs2      <= i_rs2;
                idRd       <= i_rd;
            end
            if (mulStart) begin
                mulAcc   <= '0;
                mulCand  <= opA;
                mulPlier <= aluB;
                mulStore <= storeData;
                mulCnt   <= CW'(W);
            end else if (flush) begin
                mulCnt <= '0;
            end else if (state == MUL) begin
                mulAcc   <= mulFinal;
                mulCand  <= mulCand << 1;
                mulPlier <= mulPlier >> 1;
                mulCnt   <= mulCnt - CW'(1);
            end
            out_valid     <= loadOut;
            out_reg_write <= loadOut && idRegWrite;
            out_reg_store <= loadOut && idRegStore;
            out_mem_write <= loadOut && idMemWrite;
            out_mem_read  <= loadOut && idMemRead;
            if (loadOut) begin
                out_alu_result <= retire ? aluResult : mulFinal;
                out_arg3       <= retire ? storeData : mulStore;
                out_pcp2       <= idPcp2;
                out_rs1        <= idRs1;
                out_rs2        <= idRs2;
                out_rd         <= idRd;
            end
        end
    end

endmodule
